ct_f_spsram_lane_init: RTL and testbench

- Parametrised FPGA single-port SRAM wrapper for FPGA builds; drop-in successor to the fixed-size byte-lane spsram wrappers.
- Width, depth and write-lane granularity are generic; the RAM is built from one behavioural fpga_ram instance per lane.
- Adds a hardware clear engine that fills the array with INIT_VALUE after reset or on request, plus a registered, held read port.
- Used for cache tag/data and predictor arrays that must start from a known state on FPGA.

---
 rtl/ct_f_spsram_lane_init.sv | 135 +++++++++++++
 tb/tb_ct_f_spsram_lane_init.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_f_spsram_lane_init.sv
// rtl/ct_f_spsram_lane_init.sv - lane-writable FPGA single-port SRAM with hardware clear engine
module fpga_ram #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    // Output register only loads on a read, so it holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (re) begin
            dout <= mem[addr];
        end
    end
endmodule

module ct_f_spsram_lane_init #(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   LANE_WIDTH = 8,
    parameter int                   ADDR_WIDTH = 11,
    parameter bit                   INIT_EN    = 1'b1,
    parameter logic [LANE_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    input  logic                  INIT_REQ,
    output logic                  INIT_BUSY
);
    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;

    if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of LANE_WIDTH");
    end

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_hold_q;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_din;
    logic                    clearing;
    logic                    access;
    logic                    rd_en;
    logic                    unused_wen;

    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= INIT_EN ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (INIT_REQ) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    assign clearing  = (state_q == ST_CLEAR);
    assign access    = !clearing && !CEN;
    assign rd_en     = access && GWEN;
    assign INIT_BUSY = clearing;

    // Keeps the RAM address stable while the port is idle.
    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            addr_hold_q <= '0;
        end else if (access) begin
            addr_hold_q <= A;
        end
    end

    assign ram_addr = clearing ? cnt_q : (!CEN ? A : addr_hold_q);
    assign ram_din  = clearing ? {NUM_LANES{INIT_VALUE}} : D;

    // Only lane-MSB WEN bits control writes; the rest are don't-care.
    assign unused_wen = ^WEN;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic lane_we;
        assign lane_we = clearing || (access && !GWEN && !WEN[k*LANE_WIDTH+LANE_WIDTH-1]);

        fpga_ram #(
            .AW(ADDR_WIDTH),
            .DW(LANE_WIDTH)
        ) u_ram (
            .clk  (CLK),
            .rst_n(cpurst_b),
            .we   (lane_we),
            .re   (rd_en),
            .addr (ram_addr),
            .din  (ram_din[k*LANE_WIDTH +: LANE_WIDTH]),
            .dout (Q[k*LANE_WIDTH +: LANE_WIDTH])
        );
    end
endmodule

// File: tb/tb_ct_f_spsram_lane_init.sv
// tb/tb_ct_f_spsram_lane_init.sv - scoreboard bench for ct_f_spsram_lane_init (three parameter sets)
module tb_ct_f_spsram_lane_init;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] a;
    logic        cen, gwen, init_req;
    logic [31:0] wen, d;
    logic [31:0] q0, q1, q2;
    logic        busy0, busy1, busy2;

    always #5 clk = ~clk;

    ct_f_spsram_lane_init u0 (
        .CLK(clk), .cpurst_b(rst_n), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d),
        .Q(q0), .INIT_REQ(init_req), .INIT_BUSY(busy0)
    );
    ct_f_spsram_lane_init #(.INIT_VALUE(8'hA5)) u1 (
        .CLK(clk), .cpurst_b(rst_n), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d),
        .Q(q1), .INIT_REQ(init_req), .INIT_BUSY(busy1)
    );
    ct_f_spsram_lane_init #(.INIT_EN(1'b0)) u2 (
        .CLK(clk), .cpurst_b(rst_n), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d),
        .Q(q2), .INIT_REQ(init_req), .INIT_BUSY(busy2)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
        bit          chk;
    } rd_exp_t;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } probe_t;

    rd_exp_t rq0[$], rq1[$], rq2[$];
    probe_t  pq[$];
    int      compared = 0;
    int      failed   = 0;
    int      sweep_n  = 0;
    logic [2:0] fire = '0;

    function automatic logic [31:0] q_of(input int i);
        case (i)
            0:       return q0;
            1:       return q1;
            default: return q2;
        endcase
    endfunction

    function automatic logic busy_of(input int i);
        case (i)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic int rq_size(input int i);
        case (i)
            0:       return rq0.size();
            1:       return rq1.size();
            default: return rq2.size();
        endcase
    endfunction

    function automatic rd_exp_t rq_pop(input int i);
        case (i)
            0:       return rq0.pop_front();
            1:       return rq1.pop_front();
            default: return rq2.pop_front();
        endcase
    endfunction

    task automatic check(input string nm, input int dut, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, dut, act, exp);
        end
    endtask

    // A read response is presented the cycle after a read the DUT accepted.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            fire[i] <= rst_n && !cen && gwen && !busy_of(i);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (fire[i]) begin
                if (rq_size(i) == 0) begin
                    compared++;
                    failed++;
                    $display("FAIL rd_unexpected dut%0d: got %h expected no read", i, q_of(i));
                end else begin
                    rd_exp_t e;
                    e = rq_pop(i);
                    if (e.chk) check(e.name, i, q_of(i), e.exp);
                end
            end
        end
        while (pq.size() > 0) begin
            probe_t p;
            logic [31:0] act;
            p = pq.pop_front();
            if (p.sel < 3)      act = q_of(p.sel);
            else if (p.sel < 6) act = {31'b0, busy_of(p.sel - 3)};
            else                act = sweep_n;
            check(p.name, p.sel % 3, act, p.exp);
        end
    end

    task automatic step();
        logic b;
        b = busy0;
        @(posedge clk);
        #1;
        if (b) sweep_n++;
    endtask

    task automatic idle();
        cen = 1'b1; gwen = 1'b1; wen = '1; d = '0; init_req = 1'b0;
    endtask

    task automatic probe(input string nm, input int sel, input logic [31:0] exp);
        probe_t p;
        p.name = nm; p.sel = sel; p.exp = exp;
        pq.push_back(p);
    endtask

    task automatic wr(input logic [10:0] ad, input logic [31:0] dat, input logic [31:0] w);
        a = ad; d = dat; wen = w; cen = 1'b0; gwen = 1'b0;
        step();
        idle();
    endtask

    task automatic rd(input string nm, input logic [10:0] ad, input logic [31:0] e0, input logic [31:0] e1,
                      input logic [31:0] e2, input logic [2:0] acc, input logic [2:0] chk);
        rd_exp_t e;
        e.name = nm;
        if (acc[0]) begin e.exp = e0; e.chk = chk[0]; rq0.push_back(e); end
        if (acc[1]) begin e.exp = e1; e.chk = chk[1]; rq1.push_back(e); end
        if (acc[2]) begin e.exp = e2; e.chk = chk[2]; rq2.push_back(e); end
        a = ad; cen = 1'b0; gwen = 1'b1;
        step();
        idle();
    endtask

    task automatic wait_sweep(input string nm);
        int g;
        g = 0;
        while (busy0 && g < 3000) begin
            step();
            g++;
        end
        probe(nm, 6, 32'd2048);
        probe({nm, "_busy_fall"}, 3, 32'd0);
        probe({nm, "_busy_fall"}, 4, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        a = '0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        probe("rst_busy", 3, 32'd1);
        probe("rst_busy", 4, 32'd1);
        probe("rst_busy", 5, 32'd0);
        probe("rst_q", 0, 32'd0);
        probe("rst_q", 1, 32'd0);
        probe("rst_q", 2, 32'd0);
        step();

        // Release: u0/u1 sweep and drop accesses, u2 serves them at once.
        rst_n = 1'b1;
        sweep_n = 0;
        wr(11'h010, 32'hFFFF_FFFF, 32'h0);
        rd("clear_rd_dropped", 11'h020, 32'h0, 32'h0, 32'h0, 3'b100, 3'b000);
        probe("clear_q_hold", 0, 32'h0);
        probe("clear_q_hold", 1, 32'h0);
        rd("noinit_rd", 11'h010, 32'h0, 32'h0, 32'hFFFF_FFFF, 3'b100, 3'b100);
        wait_sweep("sweep_init");

        rd("init_0",    11'h000, 32'h0, 32'hA5A5_A5A5, 32'h0, 3'b111, 3'b011);
        rd("init_1023", 11'h3FF, 32'h0, 32'hA5A5_A5A5, 32'h0, 3'b111, 3'b011);
        rd("init_2047", 11'h7FF, 32'h0, 32'hA5A5_A5A5, 32'h0, 3'b111, 3'b011);
        rd("clear_wr_dropped", 11'h010, 32'h0, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 3'b111, 3'b111);

        wr(11'h005, 32'hDEAD_BEEF, 32'h0);
        rd("full_wr", 11'h005, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b111, 3'b111);
        wr(11'h005, 32'h1122_3344, 32'hFF00_FFFF);
        rd("lane2_wr", 11'h005, 32'hDE22_BEEF, 32'hDE22_BEEF, 32'hDE22_BEEF, 3'b111, 3'b111);
        wr(11'h005, 32'h1122_3344, 32'h0000_00FF);
        rd("lane321_wr", 11'h005, 32'h1122_33EF, 32'h1122_33EF, 32'h1122_33EF, 3'b111, 3'b111);
        wr(11'h006, 32'hCAFE_F00D, 32'h7F7F_7F7F);
        rd("wen_dontcare", 11'h006, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, 3'b111, 3'b111);

        rd("hold_rd", 11'h005, 32'h1122_33EF, 32'h1122_33EF, 32'h1122_33EF, 3'b111, 3'b111);
        repeat (10) step();
        probe("idle_hold", 0, 32'h1122_33EF);
        probe("idle_hold", 2, 32'h1122_33EF);
        wr(11'h005, 32'h0, 32'h0);
        step();
        probe("hold_after_wr", 0, 32'h1122_33EF);
        probe("hold_after_wr", 1, 32'h1122_33EF);
        rd("wr_zero", 11'h005, 32'h0, 32'h0, 32'h0, 3'b111, 3'b111);
        rd("pre_req", 11'h006, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, 3'b111, 3'b111);

        // Request a sweep in the same cycle as a write.
        a = 11'h7FF; d = 32'h1234_5678; wen = '0; cen = 1'b0; gwen = 1'b0; init_req = 1'b1;
        sweep_n = 0;
        step();
        idle();
        repeat (100) step();
        a = 11'h010; d = 32'hFFFF_FFFF; wen = '0; cen = 1'b0; gwen = 1'b0; init_req = 1'b1;
        step();
        a = 11'h020; cen = 1'b0; gwen = 1'b1; init_req = 1'b0; wen = '1;
        step();
        idle();
        probe("clear_q_unchanged", 0, 32'hCAFE_F00D);
        probe("clear_q_unchanged", 1, 32'hCAFE_F00D);
        probe("clear_q_unchanged", 2, 32'hCAFE_F00D);
        wait_sweep("sweep_req");
        rd("req_7ff", 11'h7FF, 32'h0, 32'hA5A5_A5A5, 32'h0, 3'b111, 3'b111);
        rd("req_010", 11'h010, 32'h0, 32'hA5A5_A5A5, 32'h0, 3'b111, 3'b111);
        rd("req_020", 11'h020, 32'h0, 32'hA5A5_A5A5, 32'h0, 3'b111, 3'b111);

        // Reset in the middle of a sweep restarts it from address 0.
        init_req = 1'b1;
        step();
        idle();
        repeat (500) step();
        rst_n = 1'b0;
        probe("midrst_busy", 3, 32'd1);
        probe("midrst_busy", 5, 32'd0);
        probe("midrst_q", 0, 32'h0);
        probe("midrst_q", 2, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        sweep_n = 0;
        probe("rel_busy", 3, 32'd1);
        rd("noinit_first_rd", 11'h010, 32'h0, 32'h0, 32'h0, 3'b100, 3'b100);
        wait_sweep("sweep_rst");
        step();
        step();

        compared++;
        if ((rq0.size() + rq1.size() + rq2.size()) != 0) begin
            failed++;
            $display("FAIL rd_missing: got %0d outstanding expected 0", rq0.size() + rq1.size() + rq2.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
